cfu_simd_mac_pipe: RTL
======================

// Module: cfu_simd_mac_pipe
// PURPOSE
//  Parametrised, pipelined successor to the single-cycle SIMD multiply-accumulate CFU.
//  Computes a LANES-wide sum of (input+input_offset)*(filter+filter_offset) per command.
//  Accumulates into one of NUM_ACC banked accumulators.
//  Sits on the CPU custom-function-unit cmd/rsp bus; supports back-pressure on rsp_ready.
// PARAMETERS
//  LANES    4   number of signed byte lanes per command word
//  IN_W     8   signed width of one lane element
//  OFF_W    9   signed width of input_offset / filter_offset
//  ACC_W    32  signed accumulator and response width
//  NUM_ACC  4   accumulator banks (power of 2, 1..8)
//  localparam DATA_W = LANES*IN_W
// PORTS
//  clk                      in   1       clock
//  reset_n                  in   1       async active-low reset
//  cmd_valid                in   1       command offered
//  cmd_ready                out  1       command accepted when cmd_valid&cmd_ready
//  cmd_payload_function_id  in   10      [9:3] opcode, [2:0] bank select (mod NUM_ACC)
//  cmd_payload_inputs_0     in   DATA_W  input lanes (lane k = bits [k*IN_W +: IN_W])
//  cmd_payload_inputs_1     in   DATA_W  filter lanes
//  rsp_valid                out  1       response held until rsp_ready
//  rsp_ready                in   1       response consumed when rsp_valid&rsp_ready
//  rsp_payload_outputs_0    out  ACC_W   result
// BEHAVIOUR
//  Reset (async, reset_n low): rsp_valid=0, rsp_payload_outputs_0=0, stage-1 valid=0,
//   all banks=0, input_offset=128, filter_offset=0; in-flight commands are dropped.
//  Pipeline: S1 registers opcode, bank, per-lane products; S2 updates bank, loads rsp.
//   Latency = 2 cycles from accept to rsp_valid. One command per cycle when unstalled.
//  Stall: stall = rsp_valid & ~rsp_ready. While stalled, S1 and rsp hold.
//   cmd_ready = ~(stall & s1_valid). S1 may fill while rsp stalls.
//  Ordering: responses return strictly in acceptance order; no reordering, no loss.
//  Opcodes:
//   0 MAC         bank += sum; rsp = new bank value.
//   1 CLEAR       bank = 0; rsp = 0.
//   2 SET_OFFSET  input_offset = in0[OFF_W-1:0], filter_offset = in1[OFF_W-1:0]; rsp = 0.
//                 Offsets take effect at the accept edge; the next accepted command uses them.
//                 Offsets persist until the next SET_OFFSET or reset.
//   3 MAC_RDCLR   rsp = bank+sum; bank = 0 (end of an output row).
//   4 READ        rsp = bank; no state change.
//   other         rsp = 0; no state change.
//  Arithmetic:
//   lane operand is IN_W+1 bits signed: sext(elem) + offset (OFF_W <= IN_W+1).
//   product is 2*(IN_W+1) bits; the LANES products are sign-extended to ACC_W and summed.
//  Back-to-back MACs to the same bank are accumulated in S2 serially; no hazard stall.
//  Bank select: bits above log2(NUM_ACC) are ignored.
// CONFIGURATION
//  CFU_ACC_SAT_EN defined: MAC/MAC_RDCLR results clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1];
//   the clamped value is both stored and returned.
//  CFU_ACC_SAT_EN undefined: two's-complement wrap at ACC_W bits.
// TESTING
//  1 Defaults, CLEAR b0, then MAC b0 with in0=0x01010101, in1=0x02020202
//    -> rsp 1032 (4*129*2), 2 cycles after accept; a second MAC -> 2064.
//  2 SET_OFFSET in0=0, in1=0, then MAC b0 (cleared) with in0=0xFFFFFFFF, in1=0x03030303
//    -> rsp -12.
//  3 MAC b1 (in as test 1), then READ b0 after CLEAR b0 -> rsp 0 and READ b1 -> 1032;
//    MAC_RDCLR b1 -> 2064, then READ b1 -> 0.
//  4 Issue 3 MACs back-to-back with rsp_ready=0 for 4 cycles
//    -> cmd_ready drops after 2 accepts; responses 1032, 2064, 3096 arrive in order.
//  5 ACC_W=16, defaults, in0=in1=0x7F7F7F7F (sum 129540)
//    -> CFU_ACC_SAT_EN: rsp 32767; without it: rsp -1532.
//  6 Pull reset_n low mid-stream with S1 and rsp full -> rsp_valid=0 immediately;
//    after release, READ b0 -> 0 and test 1 reproduces 1032 (offsets back to 128/0).

Source files
------------

// File: rtl/cfu_simd_mac_pipe.sv
// cfu_simd_mac_pipe: two-stage pipelined SIMD multiply-accumulate CFU.
//  S1 registers opcode, bank and the per-lane products at command accept.
//  S2 reduces the products, updates the selected accumulator bank and loads
//  the held response register.
// Optional feature macro: CFU_ACC_SAT_EN (MAC results clamp instead of wrap).

// One lane: (elem + in_off) * (flt + flt_off) at IN_W+1 bit operand precision.
module cfu_simd_mac_lane #(
    parameter int IN_W  = 8,
    parameter int OFF_W = 9
) (
    input  logic signed [IN_W-1:0]       in_elem,
    input  logic signed [IN_W-1:0]       flt_elem,
    input  logic signed [OFF_W-1:0]      in_off,
    input  logic signed [OFF_W-1:0]      flt_off,
    output logic signed [2*(IN_W+1)-1:0] prod
);
    localparam int OP_W   = IN_W + 1;
    localparam int PROD_W = 2 * OP_W;

    logic signed [OP_W-1:0] op_a;
    logic signed [OP_W-1:0] op_b;

    // Offset-corrected operands, then the full-precision signed product
    always_comb begin
        op_a = OP_W'(in_elem) + OP_W'(in_off);
        op_b = OP_W'(flt_elem) + OP_W'(flt_off);
        prod = PROD_W'(op_a) * PROD_W'(op_b);
    end
endmodule

module cfu_simd_mac_pipe #(
    parameter int LANES   = 4,
    parameter int IN_W    = 8,
    parameter int OFF_W   = 9,
    parameter int ACC_W   = 32,
    parameter int NUM_ACC = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [9:0]             cmd_payload_function_id,
    input  logic [LANES*IN_W-1:0]  cmd_payload_inputs_0,
    input  logic [LANES*IN_W-1:0]  cmd_payload_inputs_1,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ACC_W-1:0]       rsp_payload_outputs_0
);
    localparam int DATA_W = LANES * IN_W;
    localparam int PROD_W = 2 * (IN_W + 1);
    // Wide enough that the bank + lane sum never overflows before clamp/wrap
    localparam int WIDE_W = ACC_W + PROD_W + LANES;
    localparam int BANK_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

    localparam logic [6:0] OP_MAC       = 7'd0;
    localparam logic [6:0] OP_CLEAR     = 7'd1;
    localparam logic [6:0] OP_SET_OFF   = 7'd2;
    localparam logic [6:0] OP_MAC_RDCLR = 7'd3;
    localparam logic [6:0] OP_READ      = 7'd4;

    typedef struct packed {
        logic [6:0]                   op;
        logic [2:0]                   bank;
        logic [LANES-1:0][PROD_W-1:0] prod;
    } s1_t;

    s1_t                          s1_q;
    logic                         s1_valid;
    logic                         stall;
    logic signed [OFF_W-1:0]      in_off;
    logic signed [OFF_W-1:0]      flt_off;
    logic [LANES-1:0][PROD_W-1:0] lane_prod;
    logic [NUM_ACC-1:0][ACC_W-1:0] acc;

    logic [BANK_W-1:0]            bank_idx;
    logic signed [ACC_W-1:0]      bank_cur;
    logic signed [WIDE_W-1:0]     sum_w;
    logic signed [WIDE_W-1:0]     acc_wide;
    logic [ACC_W-1:0]             mac_res;

    assign stall     = rsp_valid & ~rsp_ready;
    // S1 can take a new command unless both it and the response are held
    assign cmd_ready = ~(stall & s1_valid);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        cfu_simd_mac_lane #(.IN_W(IN_W), .OFF_W(OFF_W)) u_lane (
            .in_elem  (cmd_payload_inputs_0[k*IN_W +: IN_W]),
            .flt_elem (cmd_payload_inputs_1[k*IN_W +: IN_W]),
            .in_off   (in_off),
            .flt_off  (flt_off),
            .prod     (lane_prod[k])
        );
    end

    // S1: capture command and products; SET_OFFSET writes offsets at accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            in_off   <= OFF_W'(128);
            flt_off  <= '0;
        end else if (cmd_ready) begin
            s1_valid <= cmd_valid;
            if (cmd_valid) begin
                s1_q.op   <= cmd_payload_function_id[9:3];
                s1_q.bank <= cmd_payload_function_id[2:0];
                s1_q.prod <= lane_prod;
                if (cmd_payload_function_id[9:3] == OP_SET_OFF) begin
                    in_off  <= cmd_payload_inputs_0[OFF_W-1:0];
                    flt_off <= cmd_payload_inputs_1[OFF_W-1:0];
                end
            end
        end
    end

    // S2 datapath: lane reduction, bank add, clamp or wrap to ACC_W
    always_comb begin
        bank_idx = BANK_W'(s1_q.bank & 3'(NUM_ACC - 1));
        bank_cur = acc[bank_idx];
        sum_w    = '0;
        for (int k = 0; k < LANES; k++)
            sum_w = sum_w + WIDE_W'($signed(s1_q.prod[k]));
        acc_wide = WIDE_W'(bank_cur) + sum_w;
`ifdef CFU_ACC_SAT_EN
        if ((acc_wide[WIDE_W-1:ACC_W-1] != '0) && (acc_wide[WIDE_W-1:ACC_W-1] != '1))
            mac_res = acc_wide[WIDE_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                         : {1'b0, {(ACC_W-1){1'b1}}};
        else
            mac_res = acc_wide[ACC_W-1:0];
`else
        mac_res = acc_wide[ACC_W-1:0];
`endif
    end

`ifndef CFU_ACC_SAT_EN
    logic unused_hi;
    assign unused_hi = ^acc_wide[WIDE_W-1:ACC_W];
`endif

    // S2 state: bank update and response load, frozen while the response stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid             <= 1'b0;
            rsp_payload_outputs_0 <= '0;
            acc                   <= '0;
        end else if (!stall) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                case (s1_q.op)
                    OP_MAC: begin
                        acc[bank_idx]         <= mac_res;
                        rsp_payload_outputs_0 <= mac_res;
                    end
                    OP_CLEAR: begin
                        acc[bank_idx]         <= '0;
                        rsp_payload_outputs_0 <= '0;
                    end
                    OP_MAC_RDCLR: begin
                        acc[bank_idx]         <= '0;
                        rsp_payload_outputs_0 <= mac_res;
                    end
                    OP_READ:  rsp_payload_outputs_0 <= bank_cur;
                    default:  rsp_payload_outputs_0 <= '0;
                endcase
            end
        end
    end

    logic unused_w;
    assign unused_w = ^DATA_W;
endmodule
